// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: bus widths, parameter
// defaults, FSM encoding and the muxed memory command.
package bus_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int SEL_W            = 4;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Counter width able to hold 0..max, never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Wait-cycle counter for an outstanding memory access; expired is raised while
// the count sits at TIMEOUT.
module bus_timer
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = cnt_w(TIMEOUT);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (!reset || clear)
      wait_cnt <= '0;
    else if (count && !expired)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign expired = (wait_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one memory port, with
// data priority bounded by a starvation limit and a per-access timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [SEL_W-1:0]  dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              bus_error
);

  localparam int SW = cnt_w(STARVE_LIMIT);

  state_t        state, state_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic          busy, expired, done;
  mem_cmd_t      cmd;

  assign busy = (state != IDLE);

  // Cleared throughout IDLE so every FETCH/DATA entry starts from zero.
  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!busy),
    .count   (busy && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
    end
  end

  // Reset aborts the access in flight, so no completion is reported under it.
  assign done      = busy && reset && (mem_ack || expired);
  assign bus_error = done && !mem_ack;

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    cmd       = '0;
    if_ack    = 1'b0;
    dm_ack    = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (dm_req && (!if_req || starve_cnt < SW'(STARVE_LIMIT)))
          state_nx = DATA;
        else if (if_req)
          state_nx = FETCH;
      end
      FETCH: begin
        cmd.req  = 1'b1;
        cmd.sel  = '1;
        cmd.addr = if_addr;
        if (done) begin
          if_ack    = 1'b1;
          if_rdata  = mem_ack ? mem_rdata : '0;
          state_nx  = IDLE;
          starve_nx = '0;
        end
      end
      DATA: begin
        cmd.req   = 1'b1;
        cmd.we    = dm_we;
        cmd.sel   = dm_sel;
        cmd.addr  = dm_addr;
        cmd.wdata = dm_wdata;
        if (done) begin
          dm_ack   = 1'b1;
          dm_rdata = mem_ack ? mem_rdata : '0;
          state_nx = IDLE;
          if (!if_req)
            starve_nx = '0;
          else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_nx = starve_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req   = cmd.req;
  assign mem_we    = cmd.we;
  assign mem_sel   = cmd.sel;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  assign stall = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule
